// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmitter and receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } tx_state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus deglitcher for one open-drain PS/2 line.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic fe_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    // Level moves only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_o <= 1'b1;
            fe_o    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            fe_o   <= 1'b0;
            if (sync_q[1] == level_o) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                cnt_q   <= '0;
                level_o <= sync_q[1];
                fe_o    <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Define PS2_TX_TIMEOUT_EN to build the transfer watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int RTS_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_req_i,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       tx_err_o,
    output logic       rx_inhibit_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    localparam int MAXC = (INHIBIT_CYCLES > RTS_CYCLES) ?
                          INHIBIT_CYCLES : RTS_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          data_oe_q;
    logic          ack_err_q;
    logic          done_q;
    logic          err_q;
    logic          clk_lvl, clk_fe;
    logic          data_lvl, data_fe_unused;
    logic          timeout;
    logic          leaving;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .pin_i   (ps2_clk_i),
        .level_o (clk_lvl),
        .fe_o    (clk_fe)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .pin_i   (ps2_data_i),
        .level_o (data_lvl),
        .fe_o    (data_fe_unused)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wd_q;
    logic          wd_run;

    assign wd_run  = state_q inside {RTS, SEND, ACK};
    assign timeout = wd_run && (wd_q == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q <= '0;
        end else if (wd_run) begin
            wd_q <= wd_q + WW'(1);
        end else begin
            wd_q <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:      if (tx_req_i) state_d = INHIBIT;
                INHIBIT:   if (cnt_q == CW'(INHIBIT_CYCLES - 1)) state_d = RTS;
                RTS:       if (cnt_q == CW'(RTS_CYCLES - 1)) state_d = SEND;
                SEND:      if (clk_fe && bit_q == 4'd9) state_d = ACK;
                ACK:       if (clk_fe) state_d = WAIT_IDLE;
                WAIT_IDLE: if (clk_lvl && data_lvl) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    assign leaving = (state_q != IDLE) && (state_d == IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            data_oe_q <= 1'b0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= leaving;
            err_q  <= leaving && (timeout || ack_err_q);
            if (state_q != state_d || !(state_q inside {INHIBIT, RTS})) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (state_q == IDLE && tx_req_i) begin
                shreg_q   <= tx_data_i;
                ack_err_q <= 1'b0;
            end
            // Start bit stays driven after the clock is handed back.
            if (state_q == RTS && state_d == SEND) begin
                data_oe_q <= 1'b1;
                bit_q     <= '0;
            end
            if (state_q == SEND && clk_fe) begin
                bit_q <= bit_q + 4'd1;
                if (bit_q < 4'd8) begin
                    data_oe_q <= ~shreg_q[bit_q[2:0]];
                end else if (bit_q == 4'd8) begin
                    data_oe_q <= ~odd_parity(shreg_q);
                end else begin
                    data_oe_q <= 1'b0;
                end
            end
            if (state_q == ACK && clk_fe) begin
                ack_err_q <= data_lvl;
            end
            if (timeout) begin
                data_oe_q <= 1'b0;
            end
        end
    end

    always_comb begin
        ps2_clk_oe_o  = state_q inside {INHIBIT, RTS};
        ps2_data_oe_o = (state_q == RTS) || (state_q == SEND && data_oe_q);
        tx_busy_o     = state_q != IDLE;
        rx_inhibit_o  = state_q != IDLE;
        tx_done_o     = done_q;
        tx_err_o      = err_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

    typedef struct {
        logic [7:0] dat;
        logic       par;
        logic       err;
        bit         frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req = 1'b0;
    logic       tx_busy_o, tx_done_o, tx_err_o, rx_inhibit_o;
    logic       ps2_clk_oe_o, ps2_data_oe_o;
    logic       ps2_clk, ps2_data;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    logic [7:0] obs_byte;
    logic       obs_par, obs_stop, obs_start;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t e;

    assign ps2_clk  = ~(ps2_clk_oe_o | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe_o | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (40),
        .RTS_CYCLES     (8),
        .TIMEOUT_CYCLES (4000),
        .FILTER_LEN     (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tx_data_i     (tx_data),
        .tx_req_i      (tx_req),
        .tx_busy_o     (tx_busy_o),
        .tx_done_o     (tx_done_o),
        .tx_err_o      (tx_err_o),
        .rx_inhibit_o  (rx_inhibit_o),
        .ps2_clk_i     (ps2_clk),
        .ps2_data_i    (ps2_data),
        .ps2_clk_oe_o  (ps2_clk_oe_o),
        .ps2_data_oe_o (ps2_data_oe_o)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (!rst && tx_done_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected none");
            end else begin
                e = sb.pop_front();
                chk("done_err", {31'd0, tx_err_o}, {31'd0, e.err});
                chk("done_busy", {31'd0, tx_busy_o}, 32'd0);
                chk("done_oe", {30'd0, ps2_clk_oe_o, ps2_data_oe_o}, 32'd0);
                if (e.frame) begin
                    chk("frame_byte", {24'd0, obs_byte}, {24'd0, e.dat});
                    chk("frame_par", {31'd0, obs_par}, {31'd0, e.par});
                    chk("frame_stop", {31'd0, obs_stop}, 32'd1);
                    chk("frame_start", {31'd0, obs_start}, 32'd0);
                end
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic p,
                        input logic er, input bit fr);
        exp_t x;
        x.dat   = d;
        x.par   = p;
        x.err   = er;
        x.frame = fr;
        sb.push_back(x);
    endtask

    task automatic issue(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_req  = 1'b1;
        @(posedge clk);
        #1;
        tx_req = 1'b0;
    endtask

    task automatic dev_frame(input int npulse, input bit ack,
                             input int glitch_k);
        int b;
        b = 0;
        obs_byte  = 'x;
        obs_par   = 1'bx;
        obs_stop  = 1'bx;
        obs_start = 1'bx;
        while (!(tx_busy_o && !ps2_clk_oe_o && ps2_data_oe_o) && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (b >= 300) begin
            bound_fail("dev_wait_start");
            return;
        end
        obs_start = ps2_data;
        for (int k = 1; k <= npulse; k++) begin
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (k == glitch_k && c == 15) dev_clk_low = 1'b1;
                if (k == glitch_k && c == 17) dev_clk_low = 1'b0;
            end
            dev_clk_low = 1'b1;
            repeat (40) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 8) obs_byte[k-1] = ps2_data;
            if (k == 9) obs_par = ps2_data;
            if (k == 10) begin
                obs_stop = ps2_data;
                if (ack) dev_data_low = 1'b1;
            end
            if (k == 11) dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int b;
        b = 0;
        while (tx_busy_o && b < 500) begin
            @(negedge clk);
            b++;
        end
        if (b >= 500) bound_fail(name);
        @(negedge clk);
    endtask

    initial begin
        int b;
        repeat (3) @(negedge clk);
        chk("reset_outs", {26'd0, tx_busy_o, tx_done_o, tx_err_o,
            rx_inhibit_o, ps2_clk_oe_o, ps2_data_oe_o}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 0xED with acknowledge, plus request-to-send timing
        push(8'hED, 1'b1, 1'b0, 1'b1);
        issue(8'hED);
        chk("t1_clk_oe", {31'd0, ps2_clk_oe_o}, 32'd1);
        chk("t1_busy", {30'd0, tx_busy_o, rx_inhibit_o}, 32'd3);
        chk("t1_data_oe", {31'd0, ps2_data_oe_o}, 32'd0);
        repeat (39) @(posedge clk);
        #1;
        chk("inh_data_oe_low", {31'd0, ps2_data_oe_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("rts_data_oe", {31'd0, ps2_data_oe_o}, 32'd1);
        repeat (7) @(posedge clk);
        #1;
        chk("rts_clk_oe_hold", {31'd0, ps2_clk_oe_o}, 32'd1);
        @(posedge clk);
        #1;
        chk("send_clk_rel", {30'd0, ps2_clk_oe_o, ps2_data_oe_o}, 32'd1);
        dev_frame(11, 1'b1, 0);
        wait_idle("idle_ed");

        // 0x07: parity bit 0
        push(8'h07, 1'b0, 1'b0, 1'b1);
        issue(8'h07);
        dev_frame(11, 1'b1, 0);
        wait_idle("idle_07");

        // no acknowledge
        push(8'hEE, 1'b1, 1'b1, 1'b1);
        issue(8'hEE);
        dev_frame(11, 1'b0, 0);
        wait_idle("idle_noack");

        // device never clocks
`ifdef PS2_TX_TIMEOUT_EN
        push(8'hFF, 1'b1, 1'b1, 1'b0);
`endif
        issue(8'hFF);
        b = 0;
        do begin
            @(posedge clk);
            #1;
            b++;
        end while (!ps2_data_oe_o && b < 200);
        if (b >= 200) bound_fail("rts_entry");
`ifdef PS2_TX_TIMEOUT_EN
        repeat (3999) @(posedge clk);
        #1;
        chk("wd_not_yet", {31'd0, tx_done_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("wd_done_err", {30'd0, tx_done_o, tx_err_o}, 32'd3);
        chk("wd_release", {30'd0, ps2_clk_oe_o, ps2_data_oe_o}, 32'd0);
        wait_idle("idle_wd");
`else
        repeat (4100) @(posedge clk);
        #1;
        chk("nowd_busy", {31'd0, tx_busy_o}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
`endif

        // reset during bit 4
        issue(8'hA5);
        dev_frame(4, 1'b1, 0);
        repeat (40) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        chk("bit4_data_oe", {31'd0, ps2_data_oe_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_oe", {30'd0, ps2_clk_oe_o, ps2_data_oe_o}, 32'd0);
        chk("rst_busy", {31'd0, tx_busy_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);
        push(8'h5A, 1'b1, 1'b0, 1'b1);
        issue(8'h5A);
        dev_frame(11, 1'b1, 0);
        wait_idle("idle_5a");

        // request while busy ignored; clock glitch ignored
        push(8'h3C, 1'b1, 1'b0, 1'b1);
        issue(8'h3C);
        repeat (5) @(negedge clk);
        tx_data = 8'hFF;
        tx_req  = 1'b1;
        @(posedge clk);
        #1;
        tx_req = 1'b0;
        chk("busy_during_2nd", {31'd0, tx_busy_o}, 32'd1);
        dev_frame(11, 1'b1, 3);
        wait_idle("idle_3c");
        repeat (100) @(negedge clk);
        chk("no_queued_req", {31'd0, tx_busy_o}, 32'd0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
